gray_cnt_checker: RTL and testbench

Single-clock monitor that sits directly downstream of the dual N-bit / (N-1)-bit Gray counter and consumes its two count buses every sampled cycle. It converts both codes to binary, checks every transition for a legal single-step Gray increment, and checks that the (N-1)-bit code is correctly derived from the N-bit code. It also counts N-bit wrap-arounds and tracks lock/fault status through a small state machine, so counter corruption is visible at system level.

---
 rtl/gray_chk_pkg.sv | 29 ++
 rtl/gray_cnt_checker_gray_to_bin.sv | 21 ++
 rtl/gray_cnt_checker.sv | 164 ++++++++++++++++
 tb/tb_gray_cnt_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_chk_pkg.sv
// Shared types and Gray-code helpers for the dual Gray counter checker.
// Helpers work on zero-extended 32-bit values so one function covers every width.
package gray_chk_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } chk_state_e;

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // The (N-1)-bit code is the N-bit code with its two MSBs folded together.
    function automatic logic [31:0] expected_n1(input logic [31:0] g, input int unsigned n);
        logic [31:0] low_mask;
        logic [31:0] top;
        low_mask = (32'd1 << (n - 2)) - 32'd1;
        top      = ((g >> (n - 1)) ^ (g >> (n - 2))) & 32'd1;
        return (g & low_mask) | (top << (n - 2));
    endfunction

endpackage

// File: rtl/gray_cnt_checker_gray_to_bin.sv
// Parameterised combinational Gray-to-binary converter.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    logic [W-1:0] b;

    always_comb begin
        b        = '0;
        b[W-1]   = gray_i[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray_i[i];
        end
    end

    assign bin_o = b;

endmodule

// File: rtl/gray_cnt_checker.sv
// Monitor for a dual N/(N-1)-bit Gray counter: step legality, pair derivation,
// wrap counting and a lock/fault state machine. All outputs are registered.
module gray_cnt_checker
    import gray_chk_pkg::*;
#(
    parameter int N      = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8,
    parameter int RELOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      n_gr_cnt,
    input  logic [N-2:0]      n_1_gr_cnt,
    input  logic              clr,
    output logic [N-1:0]      n_bin,
    output logic [N-2:0]      n_1_bin,
    output logic              locked,
    output logic              err_seq,
    output logic              err_pair,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output chk_state_e        state_dbg
);

    localparam int RUN_W = $clog2(RELOCK + 1);

    logic [N-1:0]      n_bin_c;
    logic [N-2:0]      n_1_bin_c;

    chk_state_e        state_q,      state_d;
    logic [N-1:0]      prev_q,       prev_d;
    logic [RUN_W-1:0]  good_run_q,   good_run_d;
    logic [N-1:0]      n_bin_q,      n_bin_d;
    logic [N-2:0]      n_1_bin_q,    n_1_bin_d;
    logic              err_seq_q,    err_seq_d;
    logic              err_pair_q,   err_pair_d;
    logic              err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0]  err_cnt_q,    err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;

    logic seq_hit;
    logic pair_hit;
    logic any_err;

    gray_to_bin #(.W(N)) u_n_conv (
        .gray_i (n_gr_cnt),
        .bin_o  (n_bin_c)
    );

    gray_to_bin #(.W(N - 1)) u_n1_conv (
        .gray_i (n_1_gr_cnt),
        .bin_o  (n_1_bin_c)
    );

    // No previous sample exists while UNLOCKED, so the step check is suppressed there.
    assign seq_hit  = (state_q != UNLOCKED) && (n_bin_c != N'(prev_q + N'(1)));
    assign pair_hit = expected_n1(32'(n_gr_cnt), N) != 32'(n_1_gr_cnt);
    assign any_err  = seq_hit | pair_hit;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_run_d   = good_run_q;
        n_bin_d      = n_bin_q;
        n_1_bin_d    = n_1_bin_q;
        err_seq_d    = 1'b0;
        err_pair_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;

        // Clear is applied first so an error in the same cycle still lands.
        if (clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end

        if (en) begin
            n_bin_d    = n_bin_c;
            n_1_bin_d  = n_1_bin_c;
            prev_d     = n_bin_c;
            err_seq_d  = seq_hit;
            err_pair_d = pair_hit;

            if (any_err) begin
                err_sticky_d = 1'b1;
                if (err_cnt_d != {ERR_W{1'b1}}) begin
                    err_cnt_d = err_cnt_d + ERR_W'(1);
                end
            end

            if (state_q != UNLOCKED && !seq_hit && prev_q == {N{1'b1}} && n_bin_c == '0) begin
                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end

            case (state_q)
                UNLOCKED: begin
                    state_d    = LOCKED;
                    good_run_d = '0;
                end
                LOCKED: begin
                    if (any_err) begin
                        state_d    = FAULT;
                        good_run_d = '0;
                    end
                end
                FAULT: begin
                    if (any_err) begin
                        good_run_d = '0;
                    end else if (good_run_q == RUN_W'(RELOCK - 1)) begin
                        state_d    = LOCKED;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_run_q + RUN_W'(1);
                    end
                end
                default: begin
                    state_d    = UNLOCKED;
                    good_run_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            prev_q       <= '0;
            good_run_q   <= '0;
            n_bin_q      <= '0;
            n_1_bin_q    <= '0;
            err_seq_q    <= 1'b0;
            err_pair_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            n_bin_q      <= n_bin_d;
            n_1_bin_q    <= n_1_bin_d;
            err_seq_q    <= err_seq_d;
            err_pair_q   <= err_pair_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign n_bin      = n_bin_q;
    assign n_1_bin    = n_1_bin_q;
    assign locked     = (state_q == LOCKED);
    assign err_seq    = err_seq_q;
    assign err_pair   = err_pair_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_gray_cnt_checker.sv
// Directed bench for gray_cnt_checker: arithmetic reference model compared every
// cycle, plus literal expectations at the scenario boundaries.
module tb_gray_cnt_checker;
    import gray_chk_pkg::*;

    localparam int N      = 4;
    localparam int ERR_W  = 8;
    localparam int WRAP_W = 8;
    localparam int RELOCK = 4;
    localparam int MOD_N  = 1 << N;
    localparam int MOD_N1 = 1 << (N - 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr;
    logic [N-1:0]      n_gr_cnt;
    logic [N-2:0]      n_1_gr_cnt;
    logic [N-1:0]      n_bin;
    logic [N-2:0]      n_1_bin;
    logic              locked;
    logic              err_seq;
    logic              err_pair;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    chk_state_e        state_dbg;

    gray_cnt_checker #(
        .N(N), .ERR_W(ERR_W), .WRAP_W(WRAP_W), .RELOCK(RELOCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .n_gr_cnt   (n_gr_cnt),
        .n_1_gr_cnt (n_1_gr_cnt),
        .clr        (clr),
        .n_bin      (n_bin),
        .n_1_bin    (n_1_bin),
        .locked     (locked),
        .err_seq    (err_seq),
        .err_pair   (err_pair),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int g2b(input int g);
        int b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        return b;
    endfunction

    function automatic int b2g(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [N-1:0] gray(input int v);
        return N'(b2g(v % MOD_N));
    endfunction

    function automatic logic [N-2:0] gray_n1(input int v);
        return (N - 1)'(b2g(v % MOD_N1));
    endfunction

    int m_state;  // 0 unlocked, 1 locked, 2 fault
    int m_prev, m_run, m_nbin, m_n1bin, m_cnt, m_wrap, m_gb;
    bit m_seq, m_pair, m_sticky;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_prev = 0; m_run = 0; m_nbin = 0; m_n1bin = 0;
            m_cnt = 0; m_wrap = 0; m_seq = 0; m_pair = 0; m_sticky = 0;
        end else begin
            m_seq  = 0;
            m_pair = 0;
            if (clr) begin
                m_sticky = 0;
                m_cnt    = 0;
            end
            if (en) begin
                m_gb   = g2b(int'(n_gr_cnt));
                m_pair = (int'(n_1_gr_cnt) != b2g(m_gb % MOD_N1));
                if (m_state != 0) m_seq = (m_gb != (m_prev + 1) % MOD_N);
                if (m_state != 0 && !m_seq && m_prev == MOD_N - 1 && m_gb == 0)
                    m_wrap = (m_wrap + 1) % (1 << WRAP_W);
                if (m_seq || m_pair) begin
                    m_sticky = 1;
                    if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
                end
                case (m_state)
                    0: m_state = 1;
                    1: if (m_seq || m_pair) begin m_state = 2; m_run = 0; end
                    default: begin
                        if (m_seq || m_pair) m_run = 0;
                        else begin
                            m_run++;
                            if (m_run == RELOCK) begin m_state = 1; m_run = 0; end
                        end
                    end
                endcase
                m_prev  = m_gb;
                m_nbin  = m_gb;
                m_n1bin = g2b(int'(n_1_gr_cnt));
            end
        end
    end

    function automatic chk_state_e model_state();
        return (m_state == 0) ? UNLOCKED : (m_state == 1) ? LOCKED : FAULT;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("n_bin",      32'(n_bin),      32'(m_nbin));
            check("n_1_bin",    32'(n_1_bin),    32'(m_n1bin));
            check("locked",     32'(locked),     32'(m_state == 1));
            check("err_seq",    32'(err_seq),    32'(m_seq));
            check("err_pair",   32'(err_pair),   32'(m_pair));
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
            check("err_cnt",    32'(err_cnt),    32'(m_cnt));
            check("wrap_cnt",   32'(wrap_cnt),   32'(m_wrap));
            check("state",      32'(state_dbg),  32'(model_state()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit e, input logic [N-1:0] g, input logic [N-2:0] g1, input bit c);
        @(negedge clk);
        rst = 1'b0; en = e; n_gr_cnt = g; n_1_gr_cnt = g1; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic legal(input int v);
        step(1'b1, gray(v), gray_n1(v), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_n_bin"},   32'(n_bin),      32'd0);
        check({tag, "_n_1_bin"}, 32'(n_1_bin),    32'd0);
        check({tag, "_locked"},  32'(locked),     32'd0);
        check({tag, "_seq"},     32'(err_seq),    32'd0);
        check({tag, "_pair"},    32'(err_pair),   32'd0);
        check({tag, "_sticky"},  32'(err_sticky), 32'd0);
        check({tag, "_cnt"},     32'(err_cnt),    32'd0);
        check({tag, "_wrap"},    32'(wrap_cnt),   32'd0);
        check({tag, "_state"},   32'(state_dbg),  32'(UNLOCKED));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; n_gr_cnt = '0; n_1_gr_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        chk_on = 1'b1;

        // Legal start sequence with hand-written codes
        step(1'b1, 4'b0000, 3'b000, 1'b0);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_bin0",   32'(n_bin),  32'd0);
        step(1'b1, 4'b0001, 3'b001, 1'b0);
        check("t1_bin1",   32'(n_bin),  32'd1);
        step(1'b1, 4'b0011, 3'b011, 1'b0);
        check("t1_bin2",   32'(n_bin),  32'd2);
        step(1'b1, 4'b0010, 3'b010, 1'b0);
        check("t1_bin3",   32'(n_bin),  32'd3);
        step(1'b1, 4'b0110, 3'b110, 1'b0);
        check("t1_bin4",   32'(n_bin),  32'd4);
        check("t1_cnt",    32'(err_cnt), 32'd0);

        // Run to 15 then wrap to 0
        for (int v = 5; v <= 15; v++) legal(v);
        check("t2_bin15",  32'(n_bin),   32'd15);
        check("t2_n1_7",   32'(n_1_bin), 32'd7);
        step(1'b1, 4'b0000, 3'b000, 1'b0);
        check("t2_bin0",   32'(n_bin),    32'd0);
        check("t2_wrap",   32'(wrap_cnt), 32'd1);
        check("t2_cnt",    32'(err_cnt),  32'd0);

        // Skip 2 -> 4 while locked, then relock after four good steps
        legal(1);
        legal(2);
        step(1'b1, 4'b0110, 3'b110, 1'b0);
        check("t3_seq",    32'(err_seq),    32'd1);
        check("t3_state",  32'(state_dbg),  32'(FAULT));
        check("t3_sticky", 32'(err_sticky), 32'd1);
        check("t3_cnt",    32'(err_cnt),    32'd1);
        legal(5);
        check("t3_pulse",  32'(err_seq), 32'd0);
        legal(6);
        legal(7);
        check("t3_still",  32'(locked),  32'd0);
        legal(8);
        check("t3_relock", 32'(locked),  32'd1);

        // Mid-run reset, then a first sample that is not a successor
        do_reset();
        check_all_zero("midrst");
        legal(9);
        check("first_seq",    32'(err_seq), 32'd0);
        check("first_locked", 32'(locked),  32'd1);

        // Pair error: 0110 with 010 where 110 is required
        do_reset();
        for (int v = 0; v <= 3; v++) legal(v);
        step(1'b1, 4'b0110, 3'b010, 1'b0);
        check("t4_pair",  32'(err_pair),  32'd1);
        check("t4_seq",   32'(err_seq),   32'd0);
        check("t4_state", 32'(state_dbg), 32'(FAULT));
        check("t4_cnt",   32'(err_cnt),   32'd1);

        // clr together with an error, then clr on a clean sample
        step(1'b1, 4'b0110, 3'b110, 1'b1);
        check("t5_seq",    32'(err_seq),    32'd1);
        check("t5_sticky", 32'(err_sticky), 32'd1);
        check("t5_cnt",    32'(err_cnt),    32'd1);
        step(1'b1, gray(5), gray_n1(5), 1'b1);
        check("t5_clr_sticky", 32'(err_sticky), 32'd0);
        check("t5_clr_cnt",    32'(err_cnt),    32'd0);

        // 260 repeated samples: every one is a sequence error
        repeat (260) step(1'b1, gray(5), gray_n1(5), 1'b0);
        check("t6_sat",    32'(err_cnt),   32'd255);
        check("t6_state",  32'(state_dbg), 32'(FAULT));

        // en=0 gaps with junk on the inputs
        do_reset();
        for (int v = 0; v < 8; v++) begin
            legal(v);
            for (int k = 0; k < 2; k++) begin
                step(1'b0, N'($urandom_range(0, MOD_N - 1)),
                     (N - 1)'($urandom_range(0, MOD_N1 - 1)), 1'b0);
                check("t7_hold", 32'(n_bin),   32'(v));
                check("t7_seq",  32'(err_seq), 32'd0);
            end
        end
        check("t7_cnt",    32'(err_cnt), 32'd0);
        check("t7_locked", 32'(locked),  32'd1);

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
